// File: rtl/obd_responder.sv
// ----------------------------------------------------------------------------
// obd_responder
// Serial OBD-style diagnostic responder. Receives 2-byte requests (mode, pid)
// on a UART RX line and answers with a snapshot of the vehicle physics outputs
// on a UART TX line, 8N1 framing, CLKS_PER_BIT clocks per bit.
//
// Ports
//   clk, rst        system clock; asynchronous active-high reset
//   speed .. engine_on  live vehicle telemetry, sampled once per response
//   rx              UART receive line (idle high, asynchronous to clk)
//   tx              UART transmit line (idle high)
//   busy            high from request accept until the last stop bit ends
//   frame_err       one-cycle pulse when an RX stop bit is sampled low
//   resp_count      number of completed responses (wraps)
// ----------------------------------------------------------------------------
module obd_responder #(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  speed,
   input  logic [13:0] rpm,
   input  logic [7:0]  fuel,
   input  logic [7:0]  temp,
   input  logic [31:0] odometer_raw,
   input  logic [2:0]  gear_num,
   input  logic        ess_trigger,
   input  logic        engine_on,
   input  logic        rx,
   output logic        tx,
   output logic        busy,
   output logic        frame_err,
   output logic [15:0] resp_count
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW = $clog2(TO_CYCLES + 1);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TO_CYCLES);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {WAIT_MODE, WAIT_PID, LOAD, SEND} state_t;

   // ------------------------------------------------------------------------
   // RX deserializer
   // ------------------------------------------------------------------------
   rx_state_t       r_rx_state;
   logic            r_rx_meta, r_rx_sync, r_rx_prev;
   logic [CW-1:0]   r_rx_cnt;
   logic [2:0]      r_rx_bit;
   logic [7:0]      r_rx_shift;
   logic            r_frame_err;

   logic            w_start_det;
   logic            w_rx_stop_pt;
   logic            w_rx_done;
   logic            w_rx_ferr;

   assign w_start_det  = (r_rx_state == RX_IDLE) && r_rx_prev && !r_rx_sync;
   assign w_rx_stop_pt = (r_rx_state == RX_STOP) && (r_rx_cnt == BIT_LAST);
   assign w_rx_done    = w_rx_stop_pt &&  r_rx_sync;
   assign w_rx_ferr    = w_rx_stop_pt && !r_rx_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta   <= 1'b1;
         r_rx_sync   <= 1'b1;
         r_rx_prev   <= 1'b1;
         r_rx_state  <= RX_IDLE;
         r_rx_cnt    <= '0;
         r_rx_bit    <= '0;
         r_rx_shift  <= '0;
         r_frame_err <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here let every register see the
         // pre-edge value of its neighbours, which is what hardware flops do.
         r_rx_meta   <= rx;
         r_rx_sync   <= r_rx_meta;
         r_rx_prev   <= r_rx_sync;
         r_frame_err <= w_rx_ferr;
         case (r_rx_state)
            RX_IDLE: begin
               if (w_start_det) begin
                  r_rx_state <= RX_START;
                  r_rx_cnt   <= '0;
               end
            end
            RX_START: begin
               // Re-check the line at half-bit to reject glitches.
               if (r_rx_cnt == HALF_LAST) begin
                  r_rx_cnt   <= '0;
                  r_rx_bit   <= '0;
                  r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  r_rx_cnt <= r_rx_cnt + CW'(1);
               end
            end
            RX_DATA: begin
               if (r_rx_cnt == BIT_LAST) begin
                  r_rx_cnt   <= '0;
                  r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                  r_rx_bit   <= r_rx_bit + 3'd1;
                  if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
               end else begin
                  r_rx_cnt <= r_rx_cnt + CW'(1);
               end
            end
            RX_STOP: begin
               if (r_rx_cnt == BIT_LAST) begin
                  r_rx_cnt   <= '0;
                  r_rx_state <= RX_IDLE;
               end else begin
                  r_rx_cnt <= r_rx_cnt + CW'(1);
               end
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Response builder. Registering this into r_buf during LOAD is the
   // snapshot: all multi-byte values are captured in the same cycle.
   // ------------------------------------------------------------------------
   state_t          r_state;
   logic [7:0]      r_mode, r_pid;
   logic [3:0][7:0] r_buf;
   logic [3:0][7:0] w_buf;
   logic [2:0]      w_len;
   logic [15:0]     w_rpm_x4;
   logic [15:0]     w_odo_sat;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // held, which would otherwise infer a latch.
      w_rpm_x4  = {rpm, 2'b00};
      w_odo_sat = (|odometer_raw[31:16]) ? 16'hFFFF : odometer_raw[15:0];
      w_buf[0]  = 8'h7F;
      w_buf[1]  = 8'h01;
      w_buf[2]  = 8'h12;
      w_buf[3]  = 8'h00;
      w_len     = 3'd3;
      if (r_mode != 8'h01) begin
         w_buf[1] = r_mode;
         w_buf[2] = 8'h11;
      end else begin
         case (r_pid)
            8'h0C: begin
               w_buf[0] = 8'h41; w_buf[1] = 8'h0C;
               w_buf[2] = w_rpm_x4[15:8]; w_buf[3] = w_rpm_x4[7:0];
               w_len    = 3'd4;
            end
            8'h0D: begin w_buf[0] = 8'h41; w_buf[1] = 8'h0D; w_buf[2] = speed; end
            8'h05: begin w_buf[0] = 8'h41; w_buf[1] = 8'h05; w_buf[2] = temp + 8'd40; end
            8'h2F: begin w_buf[0] = 8'h41; w_buf[1] = 8'h2F; w_buf[2] = fuel; end
            8'h31: begin
               w_buf[0] = 8'h41; w_buf[1] = 8'h31;
               w_buf[2] = w_odo_sat[15:8]; w_buf[3] = w_odo_sat[7:0];
               w_len    = 3'd4;
            end
            8'hE0: begin
               w_buf[0] = 8'h41; w_buf[1] = 8'hE0;
               w_buf[2] = {ess_trigger, engine_on, 3'b000, gear_num};
            end
            default: ;
         endcase
      end
   end

   // NOTE: the response buffer is always written in LOAD before SEND reads
   // it, so it carries no reset and stays out of the reset tree.
   always_ff @(posedge clk) begin
      if (r_state == LOAD) r_buf <= w_buf;
   end

   // ------------------------------------------------------------------------
   // Parser + transmitter FSM
   // ------------------------------------------------------------------------
   logic [TW-1:0]   r_to_cnt;
   logic            r_tx, r_busy;
   logic [15:0]     r_resp_count;
   logic [CW-1:0]   r_tx_cnt;
   logic [3:0]      r_tx_bit;       // 0 = start, 1..8 = data, 9 = stop
   logic [8:0]      r_tx_shift;     // remaining data bits + stop bit
   logic [1:0]      r_byte_idx;
   logic [2:0]      r_len;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= WAIT_MODE;
         r_mode       <= '0;
         r_pid        <= '0;
         r_to_cnt     <= '0;
         r_tx         <= 1'b1;
         r_busy       <= 1'b0;
         r_resp_count <= '0;
         r_tx_cnt     <= '0;
         r_tx_bit     <= '0;
         r_tx_shift   <= '0;
         r_byte_idx   <= '0;
         r_len        <= '0;
      end else begin
         case (r_state)
            WAIT_MODE: begin
               if (w_rx_done) begin
                  r_mode   <= r_rx_shift;
                  r_to_cnt <= '0;
                  r_state  <= WAIT_PID;
               end
            end
            WAIT_PID: begin
               // Frame error outranks timeout; both land in WAIT_MODE.
               if (w_rx_ferr) begin
                  r_state <= WAIT_MODE;
               end else if (w_rx_done) begin
                  r_pid   <= r_rx_shift;
                  r_busy  <= 1'b1;
                  r_state <= LOAD;
               end else if (w_start_det) begin
                  r_to_cnt <= '0;
               end else if (r_to_cnt >= TO_LIMIT) begin
                  r_state <= WAIT_MODE;
               end else begin
                  r_to_cnt <= r_to_cnt + TW'(1);
               end
            end
            LOAD: begin
               // Byte 0 is taken straight from the builder; later bytes
               // come from r_buf, written this same cycle.
               r_len      <= w_len;
               r_byte_idx <= '0;
               r_tx       <= 1'b0;
               r_tx_cnt   <= '0;
               r_tx_bit   <= '0;
               r_tx_shift <= {1'b1, w_buf[0]};
               r_state    <= SEND;
            end
            SEND: begin
               if (r_tx_cnt == BIT_LAST) begin
                  r_tx_cnt <= '0;
                  if (r_tx_bit == 4'd9) begin
                     if ({1'b0, r_byte_idx} == r_len - 3'd1) begin
                        r_tx         <= 1'b1;
                        r_busy       <= 1'b0;
                        r_resp_count <= r_resp_count + 16'd1;
                        r_state      <= WAIT_MODE;
                     end else begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_tx       <= 1'b0;
                        r_tx_bit   <= '0;
                        r_tx_shift <= {1'b1, r_buf[r_byte_idx + 2'd1]};
                     end
                  end else begin
                     r_tx       <= r_tx_shift[0];
                     r_tx_shift <= {1'b0, r_tx_shift[8:1]};
                     r_tx_bit   <= r_tx_bit + 4'd1;
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + CW'(1);
               end
            end
            default: r_state <= WAIT_MODE;
         endcase
      end
   end

   assign tx         = r_tx;
   assign busy       = r_busy;
   assign frame_err  = r_frame_err;
   assign resp_count = r_resp_count;

endmodule

// File: tb/tb_obd_responder.sv
// ----------------------------------------------------------------------------
// tb_obd_responder
// Self-checking bench for obd_responder. Requests are issued on rx; the
// expected response bytes are pushed into a scoreboard queue from a
// behavioural model of the response rules, and an independent UART monitor
// on tx pops and compares every received byte.
// ----------------------------------------------------------------------------
module tb_obd_responder;

   localparam int CPB = 8;
   localparam int TOB = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  speed;
   logic [13:0] rpm;
   logic [7:0]  fuel;
   logic [7:0]  temp;
   logic [31:0] odometer_raw;
   logic [2:0]  gear_num;
   logic        ess_trigger;
   logic        engine_on;
   logic        rx;
   logic        tx;
   logic        busy;
   logic        frame_err;
   logic [15:0] resp_count;

   always #5 clk = ~clk;

   obd_responder #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
      .clk(clk), .rst(rst),
      .speed(speed), .rpm(rpm), .fuel(fuel), .temp(temp),
      .odometer_raw(odometer_raw), .gear_num(gear_num),
      .ess_trigger(ess_trigger), .engine_on(engine_on),
      .rx(rx), .tx(tx), .busy(busy), .frame_err(frame_err),
      .resp_count(resp_count)
   );

   int         checks = 0;
   int         errors = 0;
   int         exp_resp = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard monitor on tx ----------------
   initial begin : monitor
      logic [7:0] b;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && tx === 1'b0) begin
            repeat (CPB/2 - 1) @(negedge clk);
            check("tx_start_mid", {31'd0, tx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            check("tx_stop_bit", {31'd0, tx}, 32'd1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_unexpected_byte: got %02h expected none", b);
            end else begin
               e = exp_q.pop_front();
               check("tx_byte", {24'd0, b}, {24'd0, e});
            end
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic push_expected(input logic [7:0] mode, input logic [7:0] pid, output int len);
      int v;
      if (mode != 8'h01) begin
         exp_q.push_back(8'h7F); exp_q.push_back(mode); exp_q.push_back(8'h11);
         len = 3;
      end else begin
         len = 3;
         case (pid)
            8'h0C: begin
               v = int'(rpm) * 4;
               exp_q.push_back(8'h41); exp_q.push_back(8'h0C);
               exp_q.push_back(8'(v / 256)); exp_q.push_back(8'(v % 256));
               len = 4;
            end
            8'h0D: begin exp_q.push_back(8'h41); exp_q.push_back(8'h0D); exp_q.push_back(speed); end
            8'h05: begin
               exp_q.push_back(8'h41); exp_q.push_back(8'h05);
               exp_q.push_back(8'((int'(temp) + 40) % 256));
            end
            8'h2F: begin exp_q.push_back(8'h41); exp_q.push_back(8'h2F); exp_q.push_back(fuel); end
            8'h31: begin
               v = (odometer_raw > 32'd65535) ? 65535 : int'(odometer_raw);
               exp_q.push_back(8'h41); exp_q.push_back(8'h31);
               exp_q.push_back(8'(v / 256)); exp_q.push_back(8'(v % 256));
               len = 4;
            end
            8'hE0: begin
               exp_q.push_back(8'h41); exp_q.push_back(8'hE0);
               exp_q.push_back(8'(int'(ess_trigger) * 128 + int'(engine_on) * 64 + int'(gear_num)));
            end
            default: begin exp_q.push_back(8'h7F); exp_q.push_back(8'h01); exp_q.push_back(8'h12); end
         endcase
      end
   endtask

   // ---------------- stimulus helpers ----------------
   // Drives start + 8 data bits, leaves the stop level on rx and returns.
   task automatic uart_send(input logic [7:0] d, input logic stop_val);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_val;
   endtask

   task automatic send_byte(input logic [7:0] d);
      uart_send(d, 1'b1);
      repeat (CPB) @(negedge clk);
   endtask

   task automatic expect_quiet(input string name, input int n);
      int viol = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || tx !== 1'b1) viol++;
      end
      check(name, viol, 0);
   endtask

   task automatic send_pid_expect(input logic [7:0] mode, input logic [7:0] pid);
      int len, t, blen;
      push_expected(mode, pid, len);
      uart_send(pid, 1'b1);
      t = 0;
      while (busy !== 1'b1 && t < 3*CPB) begin
         @(negedge clk);
         t++;
      end
      if (busy !== 1'b1) begin
         check("busy_rise_timeout", {31'd0, busy}, 32'd1);
      end else begin
         blen = 1;
         @(negedge clk);
         check("tx_start_after_load", {31'd0, tx}, 32'd0);
         while (busy === 1'b1 && blen < 60*CPB) begin
            blen++;
            @(negedge clk);
         end
         check("busy_len", blen, 1 + 10*CPB*len);
         exp_resp++;
         check("resp_count", {16'd0, resp_count}, 32'(exp_resp % 65536));
         t = 0;
         while (exp_q.size() != 0 && t < 4*CPB) begin
            @(negedge clk);
            t++;
         end
         check("scoreboard_drained", exp_q.size(), 0);
      end
   endtask

   task automatic do_request(input logic [7:0] mode, input logic [7:0] pid, input int gap);
      send_byte(mode);
      repeat (gap) @(negedge clk);
      send_pid_expect(mode, pid);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      logic [7:0] pid_tbl [7];
      logic [7:0] m, p;
      int fe, t;
      pid_tbl = '{8'h0C, 8'h0D, 8'h05, 8'h2F, 8'h31, 8'hE0, 8'h00};

      rx = 1'b1; rst = 1'b1;
      speed = 8'd0; rpm = 14'd0; fuel = 8'd0; temp = 8'd0;
      odometer_raw = 32'd0; gear_num = 3'd1; ess_trigger = 1'b0; engine_on = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      check("reset_resp_count", {16'd0, resp_count}, 32'd0);
      rst = 1'b0;
      expect_quiet("idle_after_reset", 1000);
      check("idle_resp_count", {16'd0, resp_count}, 32'd0);

      // Directed requests
      rpm = 14'd2000;          do_request(8'h01, 8'h0C, 0);
      temp = 8'd25;            do_request(8'h01, 8'h05, 3);
      odometer_raw = 32'd70000; do_request(8'h01, 8'h31, 0);
      do_request(8'h01, 8'h55, 0);
      do_request(8'h02, 8'h0D, 0);

      // Timeout: mode 01 is discarded, 0D becomes the mode
      send_byte(8'h01);
      repeat (170) @(negedge clk);
      send_byte(8'h0D);
      expect_quiet("timeout_no_resp", 100);
      send_pid_expect(8'h0D, 8'h0D);

      // PID byte with a bad stop bit
      send_byte(8'h01);
      uart_send(8'h0C, 1'b0);
      fe = 0;
      for (int i = 0; i < CPB + 6; i++) begin
         @(negedge clk);
         if (i == CPB) rx = 1'b1;
         if (frame_err === 1'b1) fe++;
      end
      check("frame_err_width", fe, 1);
      expect_quiet("frame_err_no_resp", 60);

      // Request arriving during SEND is dropped
      speed = 8'd123;
      send_byte(8'h01);
      fork
         send_pid_expect(8'h01, 8'h0C);
         begin
            t = 0;
            while (busy !== 1'b1 && t < 30*CPB) begin
               @(negedge clk);
               t++;
            end
            repeat (2*CPB) @(negedge clk);
            send_byte(8'h01);
            send_byte(8'h0D);
         end
      join
      expect_quiet("dropped_req_no_resp", 300);

      // Randomized requests
      for (int n = 0; n < 14; n++) begin
         speed        = 8'($urandom);
         rpm          = 14'($urandom_range(0, 8000));
         fuel         = 8'($urandom_range(0, 100));
         temp         = 8'($urandom);
         odometer_raw = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 65535)) : 32'($urandom);
         gear_num     = 3'($urandom_range(1, 6));
         ess_trigger  = 1'($urandom);
         engine_on    = 1'($urandom);
         m = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h01;
         p = pid_tbl[$urandom_range(0, 6)];
         if (p == 8'h00) p = 8'($urandom);
         do_request(m, p, $urandom_range(0, 2*CPB));
      end

      check("final_scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
